// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer for the VeriRISC controller: run/step/stop
// control, halt and breakpoint handling, and a retired-instruction counter.
module phase_sequencer #(
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          run_req,
  input  logic          step_req,
  input  logic          stop_req,
  input  logic          resume,
  input  logic [AW-1:0] pc_addr,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  output logic [2:0]    phase,
  output logic          running,
  output logic          halted,
  output logic          bp_hit,
  output logic [CW-1:0] instr_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

  state_t     state, state_n;
  logic [2:0] phase_n;
  logic       first, first_n;
  logic       stop_pend, stop_pend_n;
  logic       bp_hit_n;
  logic       cnt_inc;
  logic       bp_match;

  assign running = (state == RUN) || (state == STEP);
  assign halted  = (state == HALTED);

  // first suppresses the breakpoint on the instruction we restart from
  assign bp_match = bp_en && (pc_addr == bp_addr) && (phase == 3'd0) && !first;

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    first_n     = first;
    stop_pend_n = stop_pend;
    bp_hit_n    = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE: begin
        phase_n     = 3'd0;
        stop_pend_n = 1'b0;
        if (run_req) begin
          state_n = RUN;
          first_n = 1'b1;
        end else if (step_req) begin
          state_n = STEP;
          first_n = 1'b1;
        end
      end
      RUN, STEP: begin
        if (halt) begin
          state_n     = HALTED;
          phase_n     = 3'd0;
          cnt_inc     = 1'b1;
          stop_pend_n = 1'b0;
        end else if (bp_match) begin
          state_n     = IDLE;
          bp_hit_n    = 1'b1;
          stop_pend_n = 1'b0;
        end else begin
          phase_n = phase + 3'd1;
          if (phase == 3'd0) first_n = 1'b0;
          if (state == RUN && stop_req) stop_pend_n = 1'b1;
          if (phase == 3'd7) begin
            cnt_inc = 1'b1;
            // a stop sampled on the wrap edge itself also ends here
            if (state == STEP || stop_pend || stop_req) begin
              state_n     = IDLE;
              stop_pend_n = 1'b0;
            end
          end
        end
      end
      HALTED: begin
        phase_n = 3'd0;
        if (resume) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 3'd0;
      first     <= 1'b0;
      stop_pend <= 1'b0;
      bp_hit    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      first     <= first_n;
      stop_pend <= stop_pend_n;
      bp_hit    <= bp_hit_n;
      if (cnt_inc) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: vector table, directed corner sequences and a
// randomized run checked against an abstract reference model.
module tb_phase_sequencer;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, halt, run_req, step_req, stop_req, resume, bp_en;
  logic [AW-1:0] pc_addr, bp_addr;
  logic [2:0]    phase;
  logic          running, halted, bp_hit;
  logic [CW-1:0] instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .halt(halt), .run_req(run_req), .step_req(step_req),
    .stop_req(stop_req), .resume(resume), .pc_addr(pc_addr), .bp_en(bp_en),
    .bp_addr(bp_addr), .phase(phase), .running(running), .halted(halted),
    .bp_hit(bp_hit), .instr_cnt(instr_cnt)
  );

  typedef struct {
    logic          run, step, stop, hlt;
    logic [2:0]    ph;
    logic          rn, hd;
    logic [CW-1:0] cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, s, p, h, input int ph,
                              input logic rn, hd, input int cnt);
    vec_t v;
    v.run = r; v.step = s; v.stop = p; v.hlt = h;
    v.ph = 3'(ph); v.rn = rn; v.hd = hd; v.cnt = CW'(cnt);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    halt = 0; run_req = 0; step_req = 0; stop_req = 0; resume = 0;
    bp_en = 0; pc_addr = '0; bp_addr = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Reference model: mode 0 idle, 1 run, 2 step, 3 halted.
  int m_mode, m_ph, m_cnt;
  bit m_first, m_stop, m_bp;

  task automatic model_edge();
    m_bp = 0;
    if (m_mode == 0) begin
      m_ph = 0; m_stop = 0;
      if (run_req)       begin m_mode = 1; m_first = 1; end
      else if (step_req) begin m_mode = 2; m_first = 1; end
    end else if (m_mode == 3) begin
      m_ph = 0;
      if (resume) m_mode = 0;
    end else if (halt) begin
      m_mode = 3; m_ph = 0; m_cnt = (m_cnt + 1) % (1 << CW); m_stop = 0;
    end else if (m_ph == 0 && !m_first && bp_en && pc_addr == bp_addr) begin
      m_mode = 0; m_bp = 1; m_stop = 0;
    end else begin
      if (m_mode == 1 && stop_req) m_stop = 1;
      if (m_ph == 0) m_first = 0;
      m_ph = (m_ph + 1) % 8;
      if (m_ph == 0) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (m_mode == 2 || m_stop) begin m_mode = 0; m_stop = 0; end
      end
    end
  endtask

  initial begin
    int n;
    bit found, seen;

    add(0, 1, 0, 0, 0, 1, 0, 0);
    for (int p = 1; p < 8; p++) add(0, 0, 0, 0, p, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 0, 1);
    for (int p = 1; p < 8; p++) add(0, 0, 0, 0, p, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 0, 2, 1, 0, 2);
    add(0, 0, 1, 0, 3, 1, 0, 2);
    for (int p = 4; p < 8; p++) add(0, 0, 0, 0, p, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 3);

    do_reset();
    chk("rst_phase", phase, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", instr_cnt, 0);

    foreach (tbl[i]) begin
      run_req = tbl[i].run; step_req = tbl[i].step;
      stop_req = tbl[i].stop; halt = tbl[i].hlt;
      tick();
      chk($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].rn);
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].hd);
      chk($sformatf("tbl%0d_cnt", i), instr_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_bp", i), bp_hit, 0);
    end
    idle_in();

    // continuous run, then async reset at phase 3 with count 5
    do_reset();
    run_req = 1; tick(); run_req = 0;
    repeat (24) tick();
    chk("run24_cnt", instr_cnt, 3);
    chk("run24_phase", phase, 0);
    chk("run24_running", running, 1);
    repeat (19) tick();
    chk("pre_rst_phase", phase, 3);
    chk("pre_rst_cnt", instr_cnt, 5);
    #2 rst = 1;
    #1;
    chk("async_rst_phase", phase, 0);
    chk("async_rst_cnt", instr_cnt, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_halted", halted, 0);
    chk("async_rst_bp", bp_hit, 0);
    #1 rst = 0;
    tick();
    chk("post_rst_running", running, 0);

    // halt in 2nd instruction at phase 5, with a simultaneous stop
    do_reset();
    run_req = 1; tick(); run_req = 0;
    repeat (13) tick();
    chk("pre_halt_phase", phase, 5);
    chk("pre_halt_cnt", instr_cnt, 1);
    halt = 1; stop_req = 1;
    tick();
    halt = 0; stop_req = 0;
    chk("halt_phase", phase, 0);
    chk("halt_halted", halted, 1);
    chk("halt_running", running, 0);
    chk("halt_cnt", instr_cnt, 2);
    halt = 1; run_req = 1; step_req = 1;
    repeat (3) tick();
    idle_in();
    chk("halted_hold", halted, 1);
    chk("halted_hold_cnt", instr_cnt, 2);
    chk("halted_hold_phase", phase, 0);
    resume = 1; tick(); resume = 0;
    chk("resume_halted", halted, 0);
    chk("resume_running", running, 0);
    tick();
    chk("resume_stays_idle", running, 0);

    // breakpoint at address 4, pc follows retired count
    do_reset();
    bp_en = 1; bp_addr = 5'd4; pc_addr = '0;
    run_req = 1; tick(); run_req = 0;
    n = 1; found = 0;
    while (n < 100 && !found) begin
      pc_addr = AW'(instr_cnt);
      tick();
      n++;
      if (bp_hit) found = 1;
    end
    chk("bp_found", found, 1);
    chk("bp_edge", n, 34);
    chk("bp_phase", phase, 0);
    chk("bp_running", running, 0);
    chk("bp_cnt", instr_cnt, 4);
    tick();
    chk("bp_pulse_width", bp_hit, 0);
    run_req = 1; tick(); run_req = 0;
    seen = bp_hit;
    repeat (8) begin tick(); seen = seen | bp_hit; end
    chk("bp_restart_nohit", seen, 0);
    chk("bp_restart_cnt", instr_cnt, 5);
    chk("bp_restart_running", running, 1);

    // randomized run against the reference model (count wraps at 2^CW)
    do_reset();
    m_mode = 0; m_ph = 0; m_cnt = 0; m_first = 0; m_stop = 0; m_bp = 0;
    for (int c = 0; c < 3000; c++) begin
      run_req  = ($urandom_range(0, 9) == 0);
      step_req = ($urandom_range(0, 9) == 0);
      stop_req = ($urandom_range(0, 15) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      halt     = ($urandom_range(0, 39) == 0);
      bp_en    = ($urandom_range(0, 1) == 1);
      bp_addr  = AW'($urandom_range(0, 3));
      pc_addr  = AW'($urandom_range(0, 3));
      model_edge();
      tick();
      chk("rnd_phase", phase, m_ph);
      chk("rnd_running", running, (m_mode == 1 || m_mode == 2));
      chk("rnd_halted", halted, (m_mode == 3));
      chk("rnd_bp", bp_hit, m_bp);
      chk("rnd_cnt", instr_cnt, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Upstream neighbour of the VeriRISC controller. Generates the 3-bit instruction phase (0..7) the controller decodes, consumes the controller's registered halt output, and adds run/stop/single-step/breakpoint sequencing for bench and debug use. It also keeps a retired-instruction counter.

Parameters:
AW, 5, width of pc_addr and bp_addr (VeriRISC 32-word address space)
CW, 16, width of instr_cnt

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
halt  input  1  registered halt output from the controller
run_req  input  1  level; start continuous execution when idle
step_req  input  1  level; execute exactly one instruction when idle
stop_req  input  1  level; finish current instruction, then go idle
resume  input  1  level; leave HALTED
pc_addr  input  AW  current program counter
bp_en  input  1  breakpoint enable
bp_addr  input  AW  breakpoint address
phase  output  3  phase to the controller
running  output  1  high in RUN or STEP
halted  output  1  high in HALTED
bp_hit  output  1  one-cycle pulse on breakpoint stop
instr_cnt  output  CW  retired-instruction count, wraps modulo 2^CW

Behaviour:
- Reset (async, any time, including mid-instruction): state=IDLE, phase=0, running=0, halted=0, bp_hit=0, instr_cnt=0, first flag=0. Takes effect immediately, without waiting for a clock edge.
- States: IDLE, RUN, STEP, HALTED. All outputs are registered. running and halted decode from state.
- IDLE: phase held at 0.
  - run_req -> RUN.
  - else step_req -> STEP.
  - run_req has priority over step_req.
  - On either exit, set first=1. Phase stays 0 for the first active cycle.
- RUN/STEP: phase increments by 1 on every edge, wrapping 7->0.
  - On each 7->0 wrap, instr_cnt increments.
  - STEP: on the 7->0 wrap -> IDLE.
  - RUN with stop_req sampled high at any edge: a pending-stop flag is set. At the next 7->0 wrap -> IDLE. The flag clears on entering IDLE.
  - first clears on any edge where phase leaves 0.
- Halt: when halt is sampled high in RUN or STEP:
  - phase is forced to 0, state -> HALTED, instr_cnt increments (the HALT instruction counts as retired).
  - halt has priority over stop, step completion and breakpoint.
  - halt sampled high in IDLE or HALTED is ignored.
  - Timing: the controller asserts halt during the phase-5 cycle of a HALT opcode, so the stop occurs at the phase-5 edge.
- HALTED: phase held at 0. resume -> IDLE. No other input has effect.
- Breakpoint: at an edge in RUN or STEP where phase==0, first==0, bp_en==1 and pc_addr==bp_addr:
  - phase stays 0, state -> IDLE, bp_hit=1 for exactly one cycle, instr_cnt unchanged.
  - Because first==1 on the first instruction after leaving IDLE, a restart at the breakpoint address proceeds without re-triggering.
- Event priority per edge: rst > halt > breakpoint > wrap/stop/step handling > phase increment.
- instr_cnt is never reset except by rst and wraps at all-ones->0.

Test Plan:
- Reset: assert rst mid-RUN at phase 3 with instr_cnt=5 -> immediately phase=0, instr_cnt=0, running=0, halted=0, bp_hit=0, all without a clock edge.
- Continuous run: run_req=1 for 1 cycle, halt=0, bp_en=0 -> phase sequence 0,1,...,7,0,...; after 24 edges in RUN, instr_cnt=3, running=1.
- Single step: step_req pulse from IDLE -> 8 cycles of phases 0..7, then IDLE with phase=0, instr_cnt=1, running=0.
- Halt: run, drive halt=1 at the phase-5 cycle of the 2nd instruction -> next edge phase=0, halted=1, instr_cnt=2. Further halt pulses have no effect. resume -> IDLE, halted=0.
- Breakpoint: bp_en=1, bp_addr=5'd4; pc_addr steps 0,1,2,... per instruction; run -> stop with phase=0 when pc_addr=4, bp_hit high one cycle, instr_cnt=4. run_req again -> executes address 4 without re-hit.
- Stop mid-instruction: stop_req at phase 2 in RUN -> phases 3..7 complete, then IDLE at wrap, instr_cnt incremented by 1. Simultaneous halt and stop at phase 5 -> HALTED wins.
